// File: rtl/peak_sched_pkg.sv
// Shared types for the peak-window scheduler: window record, FSM states and
// the slot-search helper used when picking the next window to issue.
package peak_sched_pkg;

    localparam int POS_W      = 8;
    localparam int N_WIN      = 3;
    localparam int SORT_STEPS = 3;

    typedef struct packed {
        logic [POS_W-1:0] start_pos;
        logic [POS_W-1:0] end_pos;
        logic [POS_W-1:0] max_pos;
        logic [1:0]       src;
    } window_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SORT,
        ST_ISSUE,
        ST_DONE
    } state_t;

    function automatic logic win_in_range(input window_t w);
        return (w.start_pos <= w.max_pos) && (w.max_pos <= w.end_pos);
    endfunction

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [2:0] next_valid(input logic [2:0] mask, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        if ((from <= 3'd2) && mask[2]) r = 3'b110;
        if ((from <= 3'd1) && mask[1]) r = 3'b101;
        if ((from == 3'd0) && mask[0]) r = 3'b100;
        return r;
    endfunction

endpackage

// File: rtl/peak_window_scheduler_cmp_swap.sv
// Stable compare-swap of two windows by max position: the pair is exchanged
// only when the lower slot's max is strictly greater.
module peak_cmp_swap
    import peak_sched_pkg::*;
(
    input  window_t a,
    input  window_t b,
    output window_t lo,
    output window_t hi
);

    logic swap;

    assign swap = a.max_pos > b.max_pos;
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/peak_window_scheduler.sv
// Latches a frame of three peak windows, orders them (sorted or fixed 2,1,3)
// and issues them over valid/ready. Optional macro: PEAK_SCHED_VALID_CHECK_EN.
module peak_window_scheduler
    import peak_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_valid,
    output logic             frame_ready,
    input  logic             frequency_mode,
    input  logic [POS_W-1:0] start_position_1,
    input  logic [POS_W-1:0] start_position_2,
    input  logic [POS_W-1:0] start_position_3,
    input  logic [POS_W-1:0] end_position_1,
    input  logic [POS_W-1:0] end_position_2,
    input  logic [POS_W-1:0] end_position_3,
    input  logic [POS_W-1:0] max_position_1,
    input  logic [POS_W-1:0] max_position_2,
    input  logic [POS_W-1:0] max_position_3,
    input  logic             abort,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [POS_W-1:0] win_start,
    output logic [POS_W-1:0] win_end,
    output logic [POS_W-1:0] win_max,
    output logic [1:0]       win_src,
    output logic [1:0]       win_idx,
    output logic             win_last,
    output logic             frame_done,
    output logic             busy
);

    state_t                  state, state_n;
    window_t [N_WIN-1:0]     slots, slots_n;
    logic                    mode_q, mode_n;
    logic [1:0]              step, step_n;
    logic [1:0]              ptr, ptr_n;
    logic [1:0]              cmp_lo;
    logic [N_WIN-1:0]        ok, ok_n;
    logic [2:0]              first_n, after_cur, after_n;
    window_t                 cmp_a, cmp_b, cmp_lo_w, cmp_hi_w;
    logic                    accept;

    assign accept = frame_valid && frame_ready;

    // One comparator serves all sort steps: step 1 works on slots (1,2), others on (0,1).
    assign cmp_lo = (step == 2'd1) ? 2'd1 : 2'd0;
    assign cmp_a  = slots[cmp_lo];
    assign cmp_b  = slots[cmp_lo + 2'd1];

    peak_cmp_swap u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .lo (cmp_lo_w),
        .hi (cmp_hi_w)
    );

    always_comb begin
        slots_n = slots;
        mode_n  = mode_q;
        step_n  = step;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    slots_n[0] = '{start_pos: start_position_1, end_pos: end_position_1,
                                   max_pos: max_position_1, src: 2'd1};
                    slots_n[1] = '{start_pos: start_position_2, end_pos: end_position_2,
                                   max_pos: max_position_2, src: 2'd2};
                    slots_n[2] = '{start_pos: start_position_3, end_pos: end_position_3,
                                   max_pos: max_position_3, src: 2'd3};
                    mode_n     = frequency_mode;
                end
            end
            ST_LOAD: begin
                step_n = 2'd0;
                if (!mode_q) begin
                    slots_n[0] = slots[1];
                    slots_n[1] = slots[0];
                end
            end
            ST_SORT: begin
                slots_n[cmp_lo]        = cmp_lo_w;
                slots_n[cmp_lo + 2'd1] = cmp_hi_w;
                step_n                 = step + 2'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ok   = '1;
        ok_n = '1;
`ifdef PEAK_SCHED_VALID_CHECK_EN
        for (int i = 0; i < N_WIN; i++) begin
            ok[i]   = win_in_range(slots[i]);
            ok_n[i] = win_in_range(slots_n[i]);
        end
`endif
    end

    assign first_n   = next_valid(ok_n, 3'd0);
    assign after_cur = next_valid(ok, {1'b0, ptr} + 3'd1);
    assign after_n   = next_valid(ok_n, {1'b0, ptr_n} + 3'd1);

    // Leaving LOAD/SORT jumps straight to DONE when no slot is eligible for issue.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        case (state)
            ST_IDLE: begin
                if (accept) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                if (mode_q) begin
                    state_n = ST_SORT;
                end else if (first_n[2]) begin
                    state_n = ST_ISSUE;
                    ptr_n   = first_n[1:0];
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_SORT: begin
                if (step == 2'(SORT_STEPS - 1)) begin
                    if (first_n[2]) begin
                        state_n = ST_ISSUE;
                        ptr_n   = first_n[1:0];
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                if (win_valid && win_ready) begin
                    if (after_cur[2]) ptr_n = after_cur[1:0];
                    else              state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        if (abort && (state != ST_IDLE)) state_n = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            slots  <= '0;
            mode_q <= 1'b0;
            step   <= 2'd0;
            ptr    <= 2'd0;
        end else begin
            state  <= state_n;
            slots  <= slots_n;
            mode_q <= mode_n;
            step   <= step_n;
            ptr    <= ptr_n;
        end
    end

    // Outputs are registered from next-state values so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_ready <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            win_valid   <= 1'b0;
            win_start   <= '0;
            win_end     <= '0;
            win_max     <= '0;
            win_src     <= 2'd0;
            win_idx     <= 2'd0;
            win_last    <= 1'b0;
        end else begin
            frame_ready <= (state_n == ST_IDLE);
            busy        <= (state_n != ST_IDLE);
            frame_done  <= (state_n == ST_DONE);
            win_valid   <= (state_n == ST_ISSUE);
            if (state_n == ST_ISSUE) begin
                win_start <= slots_n[ptr_n].start_pos;
                win_end   <= slots_n[ptr_n].end_pos;
                win_max   <= slots_n[ptr_n].max_pos;
                win_src   <= slots_n[ptr_n].src;
                win_idx   <= ptr_n;
                win_last  <= !after_n[2];
            end else begin
                win_start <= '0;
                win_end   <= '0;
                win_max   <= '0;
                win_src   <= 2'd0;
                win_idx   <= 2'd0;
                win_last  <= 1'b0;
            end
        end
    end

endmodule
